// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states
// and the mux-select codes that the datapath decodes.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_LUI, S_EXEC_AUIPC,
      S_ALU_WB, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH,
      S_JAL, S_JALR, S_RETIRE, S_TRAP
   } state_e;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_ALU    = 2'd1;
   localparam logic [1:0] PC_JALR   = 2'd2;

   localparam logic [1:0] A_RS1     = 2'd0;
   localparam logic [1:0] A_PC      = 2'd1;
   localparam logic [1:0] A_ZERO    = 2'd2;

   localparam logic [1:0] B_RS2     = 2'd0;
   localparam logic [1:0] B_IMM     = 2'd1;
   localparam logic [1:0] B_FOUR    = 2'd2;

   localparam logic [1:0] ALU_ADD    = 2'd0;
   localparam logic [1:0] ALU_FUNCT  = 2'd1;
   localparam logic [1:0] ALU_BRANCH = 2'd2;

   localparam logic [1:0] WB_ALU    = 2'd0;
   localparam logic [1:0] WB_MEM    = 2'd1;
   localparam logic [1:0] WB_PC4    = 2'd2;

   // funct3 values that name a real load / store / branch in RV32I
   function automatic logic load_f3_ok(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
   endfunction

   function automatic logic branch_f3_ok(input logic [2:0] f3);
      return (f3 != 3'd2) && (f3 != 3'd3);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: picks the state that follows DECODE,
// routing unknown opcodes and bad funct3 encodings to TRAP.
module ctrl_decode
   import rv_ctrl_pkg::*;
#(
   parameter bit FENCE_NOP = 1'b1
) (
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output state_e     decode_next
);

   always_comb begin
      decode_next = S_TRAP;
      case (opcode)
         OP_R:      decode_next = S_EXEC_R;
         OP_IMM:    decode_next = S_EXEC_I;
         OP_LOAD:   decode_next = load_f3_ok(funct3)   ? S_MEM_ADDR : S_TRAP;
         OP_STORE:  decode_next = store_f3_ok(funct3)  ? S_MEM_ADDR : S_TRAP;
         OP_BRANCH: decode_next = branch_f3_ok(funct3) ? S_BRANCH   : S_TRAP;
         OP_JAL:    decode_next = S_JAL;
         OP_JALR:   decode_next = S_JALR;
         OP_LUI:    decode_next = S_EXEC_LUI;
         OP_AUIPC:  decode_next = S_EXEC_AUIPC;
         OP_FENCE:  decode_next = FENCE_NOP ? S_RETIRE : S_TRAP;
         default:   decode_next = S_TRAP;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Main multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// and decodes every datapath select and strobe from the current state.
module mc_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int STATE_W   = 4,
   parameter bit FENCE_NOP = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               branch_taken,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_addr_sel,
   output logic               ir_we,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               reg_we,
   output logic [1:0]         wb_sel,
   output logic               illegal,
   output logic [STATE_W-1:0] dbg_state
);

   state_e state_q, state_d, decode_next;
   logic   illegal_q, illegal_d;
   logic   mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c;

   ctrl_decode #(.FENCE_NOP(FENCE_NOP)) u_decode (
      .opcode      (opcode),
      .funct3      (funct3),
      .decode_next (decode_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req_c    = 1'b0;
      mem_we_c     = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we_c      = 1'b0;
      pc_we_c      = 1'b0;
      pc_src       = PC_PLUS4;
      alu_src_a    = A_RS1;
      alu_src_b    = B_RS2;
      alu_op       = ALU_ADD;
      reg_we_c     = 1'b0;
      wb_sel       = WB_ALU;
      case (state_q)
         S_FETCH: begin
            mem_req_c = 1'b1;
            ir_we_c   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         // ALU precomputes PC+imm here so BRANCH/JAL find the target ready
         S_DECODE: begin
            alu_src_a = A_PC;
            alu_src_b = B_IMM;
            state_d   = decode_next;
         end
         S_EXEC_R: begin
            alu_op  = ALU_FUNCT;
            state_d = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_b = B_IMM;
            alu_op    = ALU_FUNCT;
            state_d   = S_ALU_WB;
         end
         S_EXEC_LUI: begin
            alu_src_a = A_ZERO;
            alu_src_b = B_IMM;
            state_d   = S_ALU_WB;
         end
         S_EXEC_AUIPC: begin
            alu_src_a = A_PC;
            alu_src_b = B_IMM;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB, S_MEM_WB: begin
            reg_we_c = 1'b1;
            wb_sel   = (state_q == S_MEM_WB) ? WB_MEM : WB_ALU;
            pc_we_c  = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_b = B_IMM;
            state_d   = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            mem_req_c    = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WR: begin
            mem_req_c    = 1'b1;
            mem_we_c     = 1'b1;
            mem_addr_sel = 1'b1;
            pc_we_c      = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_op  = ALU_BRANCH;
            pc_we_c = 1'b1;
            pc_src  = branch_taken ? PC_ALU : PC_PLUS4;
            state_d = S_FETCH;
         end
         S_JAL, S_JALR: begin
            reg_we_c = 1'b1;
            wb_sel   = WB_PC4;
            pc_we_c  = 1'b1;
            pc_src   = (state_q == S_JALR) ? PC_JALR : PC_ALU;
            state_d  = S_FETCH;
         end
         S_RETIRE: begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   // Strobes are masked by reset directly so an access in flight dies at once
   assign mem_req   = mem_req_c & ~rst;
   assign mem_we    = mem_we_c  & ~rst;
   assign ir_we     = ir_we_c   & ~rst;
   assign pc_we     = pc_we_c   & ~rst;
   assign reg_we    = reg_we_c  & ~rst;
   assign illegal_d = illegal_q | (state_d == S_TRAP);
   assign illegal   = illegal_q;
   assign dbg_state = STATE_W'(state_q);

endmodule
